// File: rtl/top_design.sv
// GCD engine built from a controller FSM and a small datapath.
// Operand A is loaded, then operand B. The engine repeatedly subtracts the
// smaller working register from the larger one until the two are equal or
// one of them is zero. The result is then held in DONE.
//
// Ports:
//   i_clk       - clock; all state changes happen on its rising edge
//   i_rst_n     - asynchronous active-low reset
//   start       - request to begin a computation (sampled in IDLE and DONE)
//   data_input  - operand bus: A during LOADA, B during LOADB
//   p_STATE     - current controller state code
//   done        - high while the result is valid (DONE state only)
//   out_A/out_B - A and B working registers
//   Sub_out     - larger minus smaller of out_A/out_B (0 when equal)
//   EQ/LT/GT    - unsigned compare of out_A against out_B
//   gcd_out     - out_B when out_A is zero, otherwise out_A
module top_design #(
  parameter int DATA_WIDTH  = 8,
  parameter int STATE_WIDTH = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  data_input,
  output logic [STATE_WIDTH-1:0] p_STATE,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  out_A,
  output logic [DATA_WIDTH-1:0]  out_B,
  output logic [DATA_WIDTH-1:0]  Sub_out,
  output logic                   EQ,
  output logic                   LT,
  output logic                   GT,
  output logic [DATA_WIDTH-1:0]  gcd_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADA = 3'd1,
    S_LOADB = 3'd2,
    S_CMP   = 3'd3,
    S_SUBA  = 3'd4,
    S_SUBB  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [2:0]            w_state_code;
  logic                  w_eq;
  logic                  w_lt;
  logic                  w_gt;
  logic [DATA_WIDTH-1:0] w_diff;

  // Datapath: comparator and larger-minus-smaller subtractor. Because the
  // subtractor always takes the larger operand first, SUBA/SUBB never wrap.
  always_comb begin
    w_eq   = (r_a == r_b);
    w_lt   = (r_a <  r_b);
    w_gt   = (r_a >  r_b);
    w_diff = '0;
    if (w_gt) begin
      w_diff = r_a - r_b;
    end else if (w_lt) begin
      w_diff = r_b - r_a;
    end
  end

  // Controller and working registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOADA;
          end
        end
        S_LOADA: begin
          r_a     <= data_input;
          r_state <= S_LOADB;
        end
        S_LOADB: begin
          r_b     <= data_input;
          r_state <= S_CMP;
        end
        S_CMP: begin
          if (w_eq || (r_a == '0) || (r_b == '0)) begin
            r_state <= S_DONE;
          end else if (w_gt) begin
            r_state <= S_SUBA;
          end else begin
            r_state <= S_SUBB;
          end
        end
        S_SUBA: begin
          r_a     <= w_diff;
          r_state <= S_CMP;
        end
        S_SUBB: begin
          r_b     <= w_diff;
          r_state <= S_CMP;
        end
        S_DONE: begin
          if (!start) begin
            r_state <= S_IDLE;
          end
        end
        // Unused code 7 recovers to IDLE.
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_state_code = r_state;
  assign p_STATE      = STATE_WIDTH'(w_state_code);
  assign done         = (r_state == S_DONE);
  assign out_A        = r_a;
  assign out_B        = r_b;
  assign Sub_out      = w_diff;
  assign EQ           = w_eq;
  assign LT           = w_lt;
  assign GT           = w_gt;
  assign gcd_out      = (r_a == '0) ? r_b : r_a;

endmodule

// File: tb/tb_top_design.sv
// Self-checking bench for the GCD engine: directed cases plus random operand
// pairs, checked against a behavioural GCD / step-count model.
module tb_top_design;

  localparam int DW = 8;
  localparam int SW = 3;

  logic          i_clk;
  logic          i_rst_n;
  logic          start;
  logic [DW-1:0] data_input;
  logic [SW-1:0] p_STATE;
  logic          done;
  logic [DW-1:0] out_A;
  logic [DW-1:0] out_B;
  logic [DW-1:0] Sub_out;
  logic          EQ;
  logic          LT;
  logic          GT;
  logic [DW-1:0] gcd_out;

  int checks   = 0;
  int failures = 0;

  top_design #(.DATA_WIDTH(DW), .STATE_WIDTH(SW)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .start      (start),
    .data_input (data_input),
    .p_STATE    (p_STATE),
    .done       (done),
    .out_A      (out_A),
    .out_B      (out_B),
    .Sub_out    (Sub_out),
    .EQ         (EQ),
    .LT         (LT),
    .GT         (GT),
    .gcd_out    (gcd_out)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Euclid by remainder; gcd(0,x)=x, gcd(0,0)=0.
  function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
    int unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Number of subtractions the subtractive algorithm performs.
  function automatic int unsigned ref_steps(input int unsigned a, input int unsigned b);
    int unsigned n = 0;
    while (a != 0 && b != 0 && a != b) begin
      if (a > b) a = a - b;
      else       b = b - a;
      n++;
    end
    return n;
  endfunction

  // Combinational outputs checked against the currently visible registers.
  task automatic check_comb(input string tag);
    int unsigned a, b;
    a = 32'(out_A);
    b = 32'(out_B);
    chk({tag, "_sub"}, 32'(Sub_out), (a > b) ? a - b : b - a);
    chk({tag, "_cmp"}, 32'({EQ, LT, GT}), (a == b) ? 32'd4 : (a < b) ? 32'd2 : 32'd1);
    chk({tag, "_gmux"}, 32'(gcd_out), (a == 0) ? b : a);
  endtask

  // Issue start, load A then B; leaves the DUT in CMP after edge 3.
  task automatic load(input int unsigned a, input int unsigned b);
    start      = 1'b1;
    data_input = DW'(a);
    tick();                                   // edge 1: IDLE -> LOADA
    chk("st_loada", 32'(p_STATE), 32'd1);
    start = 1'b0;                             // ignored from here on
    tick();                                   // edge 2: A loaded
    chk("st_loadb", 32'(p_STATE), 32'd2);
    chk("load_a", 32'(out_A), a);
    data_input = DW'(b);
    tick();                                   // edge 3: B loaded
    chk("st_cmp", 32'(p_STATE), 32'd3);
    chk("load_b", 32'(out_B), b);
    chk("done_early", 32'(done), 32'd0);
    data_input = DW'($urandom);
  endtask

  // Full computation; done must first rise after edge 4+2n.
  task automatic run_gcd(input int unsigned a, input int unsigned b, input bit go_idle);
    int unsigned edges;
    int unsigned exp_edges;
    exp_edges = 4 + 2 * ref_steps(a, b);
    load(a, b);
    edges = 3;
    while (!done && edges < exp_edges + 8) begin
      tick();
      edges++;
      check_comb("step");
    end
    chk("done_edge", edges, exp_edges);
    chk("done_state", 32'(p_STATE), 32'd6);
    chk("gcd", 32'(gcd_out), ref_gcd(a, b));
    if (go_idle) begin
      tick();
      chk("back_idle", 32'(p_STATE), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int unsigned ra, rb;
    int unsigned guard;
    logic [DW-1:0] held;

    i_rst_n    = 1'b0;
    start      = 1'b0;
    data_input = '0;
    #2;
    chk("rst_state", 32'(p_STATE), 32'd0);
    chk("rst_a", 32'(out_A), 32'd0);
    chk("rst_b", 32'(out_B), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", 32'({EQ, LT, GT}), 32'd4);
    chk("rst_sub", 32'(Sub_out), 32'd0);
    chk("rst_gcd", 32'(gcd_out), 32'd0);
    #10;
    i_rst_n = 1'b1;
    tick();
    chk("idle_hold", 32'(p_STATE), 32'd0);

    // Reference example: 80, 136 -> 8 after 16 edges.
    run_gcd(32'h50, 32'h88, 1'b1);
    // Equal operands: DONE on edge 4.
    run_gcd(32'h1B, 32'h1B, 1'b1);
    // Zero operands.
    run_gcd(32'h00, 32'h2A, 1'b1);
    run_gcd(32'h2A, 32'h00, 1'b1);
    run_gcd(32'h00, 32'h00, 1'b1);
    // Longest chain, 254 SUBA steps, no wrap.
    run_gcd(32'hFF, 32'h01, 1'b1);

    // Reset pulse in the middle of SUBA.
    load(32'hFF, 32'h01);
    guard = 0;
    while (p_STATE != 3'd4 && guard < 10) begin
      tick();
      guard++;
    end
    chk("reach_suba", 32'(p_STATE), 32'd4);
    tick();
    tick();                                   // next SUBA
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(p_STATE), 32'd0);
    chk("mid_rst_a", 32'(out_A), 32'd0);
    chk("mid_rst_b", 32'(out_B), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_flags", 32'({EQ, LT, GT}), 32'd4);
    chk("mid_rst_gcd", 32'(gcd_out), 32'd0);
    #3;
    i_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_idle", 32'(p_STATE), 32'd0);
    end

    // DONE held while start stays high, then restart.
    run_gcd(32'h24, 32'h3C, 1'b0);
    held  = gcd_out;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_state", 32'(p_STATE), 32'd6);
      chk("hold_gcd", 32'(gcd_out), 32'(held));
    end
    start = 1'b0;
    tick();
    chk("drop_idle", 32'(p_STATE), 32'd0);
    start = 1'b1;
    tick();
    chk("restart", 32'(p_STATE), 32'd1);
    start = 1'b0;
    i_rst_n = 1'b0;
    #2;
    i_rst_n = 1'b1;
    tick();

    // Random operand pairs.
    for (int k = 0; k < 12; k++) begin
      ra = $urandom_range(0, 255);
      rb = (k % 3 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
      run_gcd(ra, rb, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/top_design.md
TOP_DESIGN -- requirements
Module: top_design

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have parameter STATE_WIDTH, default 3, width of the state code output.
REQ-003 SHALL have input i_clk, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have input i_rst_n, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have input start, 1 bit: request to begin a GCD computation.
REQ-006 SHALL have input data_input, DATA_WIDTH: operand bus, A then B, unsigned.
REQ-007 SHALL have output p_STATE, STATE_WIDTH: current controller state code.
REQ-008 SHALL have output done, 1 bit: high while the result is valid.
REQ-009 SHALL have outputs out_A and out_B, DATA_WIDTH each: A and B working registers.
REQ-010 SHALL have output Sub_out, DATA_WIDTH: combinational difference, larger minus smaller of out_A and out_B (0 when equal).
REQ-011 SHALL have outputs EQ, LT, GT, 1 bit each: combinational unsigned compares of out_A vs out_B, exactly one high.
REQ-012 SHALL have output gcd_out, DATA_WIDTH: combinational, equals out_B when out_A==0, else out_A.

Function
REQ-013 SHALL be structured as a controller FSM plus a datapath (two registers, comparator, subtractor, load muxes).
REQ-014 SHALL encode states as IDLE=0, LOADA=1, LOADB=2, CMP=3, SUBA=4, SUBB=5, DONE=6; code 7 SHALL go to IDLE on the next edge.
REQ-015 IDLE: with start=1, go to LOADA; otherwise stay; registers hold.
REQ-016 LOADA: out_A <= data_input; go to LOADB unconditionally.
REQ-017 LOADB: out_B <= data_input; go to CMP unconditionally.
REQ-018 CMP: go to DONE if EQ, out_A==0, or out_B==0; else SUBA if GT; else SUBB (LT); registers hold.
REQ-019 SUBA: out_A <= out_A - out_B; go to CMP.
REQ-020 SUBB: out_B <= out_B - out_A; go to CMP.
REQ-021 DONE: done=1 and registers hold; stay while start=1; go to IDLE when start=0.
REQ-022 done SHALL be decoded only from the state register (Moore); high in DONE only.
REQ-023 Subtraction SHALL always be larger minus smaller, so no underflow or wrap occurs; arithmetic is unsigned, DATA_WIDTH bits.
REQ-024 start SHALL be ignored in LOADA through SUBB; no computation is aborted except by reset.
REQ-025 Each subtraction step SHALL cost 2 cycles (CMP + SUB); load costs 3 cycles from start sampled in IDLE.
REQ-026 gcd_out SHALL equal gcd(A,B) while done=1; gcd(0,0)=0, gcd(0,x)=gcd(x,0)=x.

Reset
REQ-027 i_rst_n=0 SHALL immediately force state IDLE (p_STATE=0), out_A=0, out_B=0, done=0, regardless of clock.
REQ-028 Reset asserted mid-computation SHALL discard it; after release the block waits in IDLE for start.
REQ-029 After reset: EQ=1, LT=0, GT=0, Sub_out=0, gcd_out=0.

Verification
REQ-030 Reset pulse mid-SUBA -> all outputs at reset values before the next clock edge; IDLE held while start=0.
REQ-031 start=1; data_input=0x50 at LOADA, 0x88 at LOADB -> B:136->56, A:80->24, B->32, B->8, A->16, A->8; done first high after 16th rising edge (start-sampling edge = 1); gcd_out=0x08.
REQ-032 A=0x1B, B=0x1B -> CMP->DONE on the 4th edge; gcd_out=0x1B, no subtraction.
REQ-033 A=0x00, B=0x2A -> DONE without subtracting; gcd_out=0x2A; A=0, B=0 -> gcd_out=0x00.
REQ-034 A=0xFF, B=0x01 -> 254 SUBA steps, no wrap; gcd_out=0x01; Sub_out always equals |out_A-out_B|.
REQ-035 Hold start=1 in DONE -> stays DONE with values held; drop start for 1 cycle -> IDLE; raise start -> new computation starts at LOADA.
